// File: rtl/d_arb_pkg.sv
// d_arb_pkg -- shared definitions for the shared D-register arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, GRANT, DONE)
//   DEF_N_REQ   : default number of requesters
//   DEF_WIDTH   : default width of the shared D register
//   CNT_W       : width of the completed-write counter
package d_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/d_reg_arbiter_if.sv
// d_reg_arbiter_if -- requester/bus bundle of the shared D-register arbiter.
//   req    : per-requester write request, level, held until ack
//   d      : packed write data, slice i belongs to requester i
//   grant  : one-hot grant, high for the GRANT cycle only
//   ack    : one-hot one-cycle write-complete pulse
//   q      : shared D register contents
//   busy   : arbiter is not IDLE
//   wr_cnt : completed writes, wraps modulo 256
//   state  : FSM state, exported for observation
//
// Handshake: requester i raises req[i] with d slice i stable and keeps both
// until it sees ack[i]; grant[i] alone does not complete the write, and a
// request dropped while granted aborts that write without side effects.
interface d_reg_arbiter_if #(
    parameter int N_REQ = d_arb_pkg::DEF_N_REQ,
    parameter int WIDTH = d_arb_pkg::DEF_WIDTH
) ();

    logic [N_REQ-1:0]                req;
    logic [N_REQ*WIDTH-1:0]          d;
    logic [N_REQ-1:0]                grant;
    logic [N_REQ-1:0]                ack;
    logic [WIDTH-1:0]                q;
    logic                            busy;
    logic [d_arb_pkg::CNT_W-1:0]     wr_cnt;
    d_arb_pkg::arb_state_t           state;

    modport slave (
        input  req, d,
        output grant, ack, q, busy, wr_cnt, state
    );

    modport master (
        output req, d,
        input  grant, ack, q, busy, wr_cnt, state
    );

endinterface

// File: rtl/d_reg_n.sv
// d_reg_n -- WIDTH-bit D register with load enable and async active-low clear.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   en    : load enable
//   d     : data in
//   q     : register contents
module d_reg_n #(
    parameter int WIDTH = d_arb_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_reg_arbiter.sv
// d_reg_arbiter -- round-robin arbiter granting N_REQ requesters write access
// to one shared WIDTH-bit D register. One write takes three cycles:
// IDLE (pick winner) -> GRANT (commit if still requested) -> DONE (ack).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : d_reg_arbiter_if slave (req, d in; grant, ack, q, busy, wr_cnt,
//           state out)
module d_reg_arbiter
    import d_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    d_reg_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state, state_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx;     // highest-priority index for next pick
    logic [IDX_W-1:0]  win, win_nx;     // requester owning the current grant
    logic [IDX_W-1:0]  sel;             // round-robin pick from current req
    logic [N_REQ-1:0]  grant_r, grant_nx;
    logic [N_REQ-1:0]  ack_r, ack_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              busy_r, busy_nx;
    logic              load;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  q_w;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan ptr, ptr+1, ... (mod N_REQ); the first set request wins.
    always_comb begin
        logic found;
        int   idx;
        sel   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign wr_data = bus.d[int'(win)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            grant_r <= '0;
            ack_r   <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            win     <= win_nx;
            grant_r <= grant_nx;
            ack_r   <= ack_nx;
            cnt     <= cnt_nx;
            busy_r  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        win_nx   = win;
        grant_nx = '0;
        ack_nx   = '0;
        cnt_nx   = cnt;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    win_nx   = sel;
                    grant_nx = onehot(sel);
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // A request withdrawn while granted leaves q, count and
                // priority untouched.
                if (bus.req[win]) begin
                    load     = 1'b1;
                    ack_nx   = onehot(win);
                    cnt_nx   = cnt + 1'b1;
                    ptr_nx   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // busy is registered alongside state so it tracks state exactly.
        busy_nx = (state_nx != IDLE);
    end

    d_reg_n #(.WIDTH(WIDTH)) u_d_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .d     (wr_data),
        .q     (q_w)
    );

    assign bus.grant  = grant_r;
    assign bus.ack    = ack_r;
    assign bus.q      = q_w;
    assign bus.busy   = busy_r;
    assign bus.wr_cnt = cnt;
    assign bus.state  = state;

endmodule

// File: tb/tb_d_reg_arbiter.sv
// tb_d_reg_arbiter -- self-checking bench for d_reg_arbiter (N_REQ=4, WIDTH=8).
// Expected values come from a transaction-level model: a priority pointer,
// the last written value and a write count, updated per completed write.
module tb_d_reg_arbiter;
    import d_arb_pkg::*;

    logic clk;
    logic rst_n;

    d_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    d_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    int          m_ptr;
    logic [7:0]  m_q;
    logic [7:0]  m_cnt;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_q   = 8'h00;
        m_cnt = 8'h00;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_q"},     32'(bus.q),      32'h0);
        check({tag, "_grant"}, 32'(bus.grant),  32'h0);
        check({tag, "_ack"},   32'(bus.ack),    32'h0);
        check({tag, "_cnt"},   32'(bus.wr_cnt), 32'h0);
        check({tag, "_busy"},  32'(bus.busy),   32'h0);
        check({tag, "_state"}, 32'(bus.state),  32'(IDLE));
    endtask

    // One complete write; hold keeps the winner's request up after its ack.
    task automatic run_write(input logic [3:0] r, input logic [31:0] dv, input bit hold);
        int w;
        w       = rr_pick(r, m_ptr);
        bus.req = r;
        bus.d   = dv;
        tick();
        check("wr_grant",  32'(bus.grant), 32'(1) << w);
        check("wr_ack0",   32'(bus.ack),   32'h0);
        check("wr_busy1",  32'(bus.busy),  32'h1);
        check("wr_st_g",   32'(bus.state), 32'(GRANT));
        tick();
        m_q   = dv[w*8 +: 8];
        m_cnt = m_cnt + 8'd1;
        m_ptr = (w + 1) % 4;
        check("wr_grant0", 32'(bus.grant),  32'h0);
        check("wr_ack",    32'(bus.ack),    32'(1) << w);
        check("wr_q",      32'(bus.q),      32'(m_q));
        check("wr_cnt",    32'(bus.wr_cnt), 32'(m_cnt));
        check("wr_st_d",   32'(bus.state),  32'(DONE));
        if (!hold) bus.req[w] = 1'b0;
        tick();
        check("wr_ack_clr", 32'(bus.ack),   32'h0);
        check("wr_busy0",   32'(bus.busy),  32'h0);
        check("wr_st_i",    32'(bus.state), 32'(IDLE));
        check("wr_q_hold",  32'(bus.q),     32'(m_q));
    endtask

    // Winner drops its request during GRANT: nothing may change.
    task automatic run_abort(input logic [3:0] r, input logic [31:0] dv);
        int w;
        w       = rr_pick(r, m_ptr);
        bus.req = r;
        bus.d   = dv;
        tick();
        check("ab_grant", 32'(bus.grant), 32'(1) << w);
        bus.req[w] = 1'b0;
        tick();
        check("ab_ack",   32'(bus.ack),    32'h0);
        check("ab_grant0",32'(bus.grant),  32'h0);
        check("ab_busy",  32'(bus.busy),   32'h0);
        check("ab_q",     32'(bus.q),      32'(m_q));
        check("ab_cnt",   32'(bus.wr_cnt), 32'(m_cnt));
        check("ab_state", 32'(bus.state),  32'(IDLE));
        bus.req = 4'b0000;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [7:0]  fair_q [5];
    logic [31:0] dv;

    initial begin
        fair_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        model_reset();

        // Reset held with all requests up: everything stays zero.
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.d   = 32'h13121110;
        #2;  check_idle_zero("rst_a");
        #5;  check_idle_zero("rst_b");
        #4;  check_idle_zero("rst_c");
        #1;  rst_n = 1'b1;

        // Fairness: all held, acks 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            run_write(4'b1111, 32'h13121110, 1'b1);
            check("fair_q", 32'(bus.q), 32'(fair_q[i]));
        end
        bus.req = 4'b0000;
        tick();

        // Single request from requester 2.
        dv = $urandom;
        dv[23:16] = 8'hA5;
        run_write(4'b0100, dv, 1'b0);
        check("single_q", 32'(bus.q), 32'hA5);

        // Abort, then priority must be unchanged.
        run_abort(4'b0001, $urandom);
        run_write(4'b1011, $urandom, 1'b0);
        run_write(4'b0001, $urandom, 1'b0);

        // Reset during DONE.
        bus.req = 4'b0010;
        bus.d   = $urandom;
        tick();
        tick();
        check("rd_ack_pre", 32'(bus.ack), 32'b0010);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("rst_done");
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        run_write(4'b1000, $urandom, 1'b0);
        run_write(4'b1001, $urandom, 1'b0);

        // Reset during GRANT discards the pending write.
        bus.req = 4'b0100;
        bus.d   = 32'h00A50000;
        tick();
        check("rg_grant", 32'(bus.grant), 32'b0100);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("rst_grant");
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        tick();
        tick();
        check("rg_q_after", 32'(bus.q),    32'h0);
        check("rg_busy",    32'(bus.busy), 32'h0);

        // Random traffic: 256 completed writes from zero wrap the counter.
        for (int n = 0; n < 256; n++) begin
            if ($urandom_range(0, 7) == 0)
                run_abort(4'($urandom_range(1, 15)), $urandom);
            run_write(4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)));
        end
        check("wrap_cnt", 32'(bus.wr_cnt), 32'h0);
        check("wrap_q",   32'(bus.q),      32'(m_q));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
